// File: rtl/uart_line_rx.sv
// Line framer for the UART receive byte stream: collects bytes until CR LF, an idle
// timeout or a buffer overflow, then holds the finished line until acknowledged.
module uart_line_rx #(
  parameter int BUF_DEPTH   = 64,
  parameter int TIMEOUT_CLK = 49_999
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_vld,
  output logic                         line_vld,
  output logic [$clog2(BUF_DEPTH):0]   line_len,
  output logic                         line_timeout,
  output logic                         line_ovf,
  input  logic [$clog2(BUF_DEPTH)-1:0] rd_addr,
  output logic [7:0]                   rd_data,
  input  logic                         line_ack
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (TIMEOUT_CLK < 1) ? 1 : $clog2(TIMEOUT_CLK + 1);
  localparam logic [LW-1:0] DEPTH = LW'(BUF_DEPTH);
  localparam logic [CW-1:0] TMO   = CW'(TIMEOUT_CLK);
  localparam logic [7:0]    CR    = 8'h0D;
  localparam logic [7:0]    LF    = 8'h0A;

  typedef enum logic [2:0] {
    S0_IDLE,
    S1_RECV,
    S2_CR,
    S3_DONE,
    S4_DISCARD
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   wptr, wptr_nxt, wptr_p1;
  logic [CW-1:0]   idle_cnt;
  logic            tmo_nxt, ovf_nxt;
  logic            we0, we1;
  logic [7:0]      wdata0;
  logic            full, tmo_hit, active;
  logic [7:0]      mem [BUF_DEPTH];

  assign wptr_p1  = wptr + LW'(1);
  assign full     = (wptr == DEPTH);
  assign tmo_hit  = (idle_cnt == TMO);
  assign active   = (state == S1_RECV) || (state == S2_CR) || (state == S4_DISCARD);
  assign line_vld = (state == S3_DONE);
  assign line_len = wptr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S0_IDLE;
      wptr         <= '0;
      line_timeout <= 1'b0;
      line_ovf     <= 1'b0;
    end else begin
      state        <= state_nxt;
      wptr         <= wptr_nxt;
      line_timeout <= tmo_nxt;
      line_ovf     <= ovf_nxt;
    end
  end

  // A byte always beats a timeout: the rx_vld branches are tested before tmo_hit.
  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    tmo_nxt   = line_timeout;
    ovf_nxt   = line_ovf;
    we0       = 1'b0;
    we1       = 1'b0;
    wdata0    = rx_data;
    unique case (state)
      S0_IDLE: begin
        if (rx_vld) begin
          if (rx_data == CR) begin
            state_nxt = S2_CR;
          end else if (rx_data != LF) begin
            we0       = 1'b1;
            wptr_nxt  = LW'(1);
            state_nxt = S1_RECV;
          end
        end
      end
      S1_RECV: begin
        if (rx_vld) begin
          if (rx_data == CR) begin
            state_nxt = S2_CR;
          end else if (full) begin
            state_nxt = S4_DISCARD;
            ovf_nxt   = 1'b1;
          end else begin
            we0      = 1'b1;
            wptr_nxt = wptr_p1;
          end
        end else if (tmo_hit) begin
          state_nxt = S3_DONE;
          tmo_nxt   = 1'b1;
        end
      end
      S2_CR: begin
        if (rx_vld) begin
          if (rx_data == LF) begin
            state_nxt = (wptr == '0) ? S0_IDLE : S3_DONE;
          end else if (full) begin
            state_nxt = S4_DISCARD;
            ovf_nxt   = 1'b1;
          end else begin
            // The held CR turns out to be data; it and the new byte may land together.
            we0    = 1'b1;
            wdata0 = CR;
            if (rx_data == CR) begin
              wptr_nxt = wptr_p1;
            end else if (wptr_p1 == DEPTH) begin
              wptr_nxt  = wptr_p1;
              state_nxt = S4_DISCARD;
              ovf_nxt   = 1'b1;
            end else begin
              we1       = 1'b1;
              wptr_nxt  = wptr + LW'(2);
              state_nxt = S1_RECV;
            end
          end
        end else if (tmo_hit) begin
          if (!full) begin
            we0      = 1'b1;
            wdata0   = CR;
            wptr_nxt = wptr_p1;
          end
          state_nxt = S3_DONE;
          tmo_nxt   = 1'b1;
        end
      end
      S4_DISCARD: begin
        if (rx_vld) begin
          if (rx_data == LF) state_nxt = S3_DONE;
        end else if (tmo_hit) begin
          state_nxt = S3_DONE;
          tmo_nxt   = 1'b1;
        end
      end
      S3_DONE: begin
        if (line_ack) begin
          state_nxt = S0_IDLE;
          wptr_nxt  = '0;
          tmo_nxt   = 1'b0;
          ovf_nxt   = 1'b0;
        end
      end
      default: state_nxt = S0_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt <= '0;
    end else if (rx_vld || !active || (state_nxt != state)) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TMO) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (we0) mem[wptr[AW-1:0]] <= wdata0;
    if (we1) mem[wptr_p1[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rd_data <= 8'h00;
    else            rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_uart_line_rx.sv
// Bench for uart_line_rx: queue-based line model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_uart_line_rx;

  localparam int BUF_DEPTH   = 64;
  localparam int TIMEOUT_CLK = 20;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_vld    = 1'b0;
  logic [5:0] rd_addr   = 6'd0;
  logic       line_ack  = 1'b0;
  logic       line_vld;
  logic [6:0] line_len;
  logic       line_timeout;
  logic       line_ovf;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  int cyc;

  uart_line_rx #(.BUF_DEPTH(BUF_DEPTH), .TIMEOUT_CLK(TIMEOUT_CLK)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .rx_data      (rx_data),
    .rx_vld       (rx_vld),
    .line_vld     (line_vld),
    .line_len     (line_len),
    .line_timeout (line_timeout),
    .line_ovf     (line_ovf),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .line_ack     (line_ack)
  );

  always #5 sys_clk = ~sys_clk;

  // Model: the line is a byte queue; a CR is held aside until the next byte says what it was.
  logic [7:0] m_q [$];
  bit         m_pcr, m_disc, m_done, m_tmo, m_ovf, m_rd_ok;
  int         m_idle;
  logic [7:0] m_rd;

  function automatic void m_clear();
    m_q.delete();
    m_pcr  = 1'b0;
    m_disc = 1'b0;
    m_done = 1'b0;
    m_tmo  = 1'b0;
    m_ovf  = 1'b0;
    m_idle = 0;
  endfunction

  function automatic void m_store(input logic [7:0] b);
    if (m_q.size() == BUF_DEPTH) begin
      m_disc = 1'b1;
      m_ovf  = 1'b1;
    end else begin
      m_q.push_back(b);
    end
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    m_idle = 0;
    if (m_disc) begin
      if (b == LF) m_done = 1'b1;
    end else if (m_pcr) begin
      m_pcr = 1'b0;
      if (b == LF) begin
        if (m_q.size() > 0) m_done = 1'b1;
      end else begin
        m_store(CR);
        if (!m_disc) begin
          if (b == CR) m_pcr = 1'b1;
          else         m_store(b);
        end
      end
    end else if (b == CR) begin
      m_pcr = 1'b1;
    end else if (!(b == LF && m_q.size() == 0)) begin
      m_store(b);
    end
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_clear();
      m_rd    = 8'h00;
      m_rd_ok = 1'b1;
    end else begin
      m_rd_ok = (int'(rd_addr) < m_q.size());
      if (m_rd_ok) m_rd = m_q[rd_addr];
      if (m_done) begin
        if (line_ack) m_clear();
      end else if (rx_vld) begin
        m_byte(rx_data);
      end else if (m_q.size() > 0 || m_pcr || m_disc) begin
        if (m_idle == TIMEOUT_CLK) begin
          if (m_pcr && m_q.size() < BUF_DEPTH) m_q.push_back(CR);
          m_pcr  = 1'b0;
          m_done = 1'b1;
          m_tmo  = 1'b1;
        end else begin
          m_idle++;
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      checkOutput("line_vld", 32'(line_vld), 32'(m_done));
      checkOutput("line_len", 32'(line_len), 32'(m_q.size()));
      checkOutput("line_timeout", 32'(line_timeout), 32'(m_tmo));
      checkOutput("line_ovf", 32'(line_ovf), 32'(m_ovf));
      if (m_rd_ok) checkOutput("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge sys_clk);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge sys_clk);
    rx_vld  = 1'b0;
  endtask

  task automatic sendText(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
  endtask

  task automatic sendLineEnd();
    applyStimulus(CR);
    applyStimulus(LF);
  endtask

  task automatic ackLine();
    @(negedge sys_clk);
    line_ack = 1'b1;
    @(negedge sys_clk);
    line_ack = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [5:0] addr, input logic [7:0] exp);
    @(negedge sys_clk);
    rd_addr = addr;
    @(negedge sys_clk);
    checkOutput(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic waitLine(input int limit, output int cycles);
    cycles = 0;
    while (!line_vld && cycles < limit) begin
      @(negedge sys_clk);
      cycles++;
    end
    checkOutput("wait_line_vld", 32'(line_vld), 32'd1);
  endtask

  task automatic checkHeld(input string name, input int len, input bit tmo, input bit ovf);
    checkOutput({name, "_vld"}, 32'(line_vld), 32'd1);
    checkOutput({name, "_len"}, 32'(line_len), 32'(len));
    checkOutput({name, "_tmo"}, 32'(line_timeout), 32'(tmo));
    checkOutput({name, "_ovf"}, 32'(line_ovf), 32'(ovf));
  endtask

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 sys_rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_vld", 32'(line_vld), 32'd0);
    checkOutput("rst_len", 32'(line_len), 32'd0);
    checkOutput("rst_rd", 32'(rd_data), 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    $display("[TB] basic CR LF line");
    sendText("AB");
    sendLineEnd();
    checkHeld("t1", 2, 1'b0, 1'b0);
    readCheck("t1_rd0", 6'd0, 8'h41);
    readCheck("t1_rd1", 6'd1, 8'h42);
    ackLine();
    checkOutput("t1_released", 32'(line_vld), 32'd0);

    $display("[TB] idle timeout");
    sendText("XYZ");
    waitLine(TIMEOUT_CLK + 10, cyc);
    checkOutput("t2_latency", 32'(cyc), 32'(TIMEOUT_CLK + 1));
    checkHeld("t2", 3, 1'b1, 1'b0);
    ackLine();
    applyStimulus("M");
    repeat (TIMEOUT_CLK - 2) @(negedge sys_clk);
    applyStimulus("N");
    repeat (TIMEOUT_CLK - 1) @(negedge sys_clk);
    applyStimulus("O");
    sendLineEnd();
    checkHeld("t2_gap", 3, 1'b0, 1'b0);
    readCheck("t2_rd2", 6'd2, 8'h4F);
    ackLine();

    $display("[TB] embedded CR");
    sendText("A");
    applyStimulus(CR);
    sendText("B");
    sendLineEnd();
    checkHeld("t3", 3, 1'b0, 1'b0);
    readCheck("t3_rd0", 6'd0, 8'h41);
    readCheck("t3_rd1", 6'd1, 8'h0D);
    readCheck("t3_rd2", 6'd2, 8'h42);
    ackLine();
    applyStimulus("P");
    applyStimulus(CR);
    waitLine(TIMEOUT_CLK + 10, cyc);
    checkHeld("t3_tmo_cr", 2, 1'b1, 1'b0);
    readCheck("t3_tmo_rd1", 6'd1, 8'h0D);
    ackLine();

    $display("[TB] full buffer and overflow");
    for (int i = 0; i < 64; i++) applyStimulus(8'(i));
    sendLineEnd();
    checkHeld("t4_full", 64, 1'b0, 1'b0);
    readCheck("t4_full_rd63", 6'd63, 8'h3F);
    ackLine();
    for (int i = 0; i < 66; i++) applyStimulus(8'(i));
    sendLineEnd();
    checkHeld("t4_ovf", 64, 1'b0, 1'b1);
    readCheck("t4_ovf_rd63", 6'd63, 8'h3F);
    ackLine();
    for (int i = 0; i < 63; i++) applyStimulus(8'(i));
    applyStimulus(CR);
    sendText("X");
    sendLineEnd();
    checkHeld("t4_crsplit", 64, 1'b0, 1'b1);
    readCheck("t4_crsplit_rd63", 6'd63, 8'h0D);
    ackLine();

    $display("[TB] empty line");
    sendLineEnd();
    repeat (2) @(negedge sys_clk);
    checkOutput("t5_empty_vld", 32'(line_vld), 32'd0);
    sendText("Q");
    sendLineEnd();
    checkHeld("t5", 1, 1'b0, 1'b0);
    readCheck("t5_rd0", 6'd0, 8'h51);
    ackLine();

    $display("[TB] bytes while held, ack collision, async reset");
    sendText("K");
    sendLineEnd();
    sendText("ZZ");
    checkHeld("t6_held", 1, 1'b0, 1'b0);
    @(negedge sys_clk);
    rx_data  = "W";
    rx_vld   = 1'b1;
    line_ack = 1'b1;
    @(negedge sys_clk);
    rx_vld   = 1'b0;
    line_ack = 1'b0;
    checkOutput("t6_ack_vld", 32'(line_vld), 32'd0);
    checkOutput("t6_ack_len", 32'(line_len), 32'd0);
    sendText("C");
    sendLineEnd();
    checkHeld("t6_next", 1, 1'b0, 1'b0);
    readCheck("t6_next_rd0", 6'd0, 8'h43);
    ackLine();
    sendText("AB");
    #2 sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checkOutput("t6_rst_vld", 32'(line_vld), 32'd0);
    checkOutput("t6_rst_len", 32'(line_len), 32'd0);
    checkOutput("t6_rst_rd", 32'(rd_data), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    sendText("C");
    sendLineEnd();
    checkHeld("t6_after_rst", 1, 1'b0, 1'b0);
    readCheck("t6_after_rst_rd0", 6'd0, 8'h43);
    ackLine();

    repeat (2) @(negedge sys_clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_line_rx.md
Name: uart_line_rx

Overview:
- Receive-side line framer for the UART byte stream. It is the reader for the echo path, which terminates every message with "\r\n".
- Consumes bytes from the uart_rx byte interface (rx_data/rx_vld) and stores them in a line buffer until CR LF arrives, an idle timeout expires, or the buffer overflows.
- On completion it presents the line (length, status flags, random-access read port) to downstream command logic and holds it until acknowledged.

Parameters:
BUF_DEPTH, 64, line buffer depth in bytes (power of two, at most 128)
TIMEOUT_CLK, 49_999, inter-byte idle limit in sys_clk cycles minus 1 (1 ms at 50 MHz)

Ports:
sys_clk  in  1  system clock, all logic on posedge
sys_rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid when rx_vld=1
rx_vld  in  1  one-cycle strobe per received byte
line_vld  out  1  high while a completed line is held
line_len  out  7  payload byte count, excluding CR LF, range 0..BUF_DEPTH
line_timeout  out  1  line was closed by idle timeout, no CR LF
line_ovf  out  1  bytes were lost because the buffer was full
rd_addr  in  6  buffer read address (log2 BUF_DEPTH)
rd_data  out  8  buffer[rd_addr], registered, 1-cycle latency
line_ack  in  1  one-cycle strobe; releases the held line

Behaviour:
- Reset values: line_vld=0, line_len=0, line_timeout=0, line_ovf=0, rd_data=0, state=S0_IDLE, write pointer=0, idle counter=0. Buffer contents need not be reset.
- The asynchronous reset aborts any line in progress; no partial line is ever presented.

State machine:
- S0_IDLE: buffer empty.
  - rx_vld with a non-CR byte: store at wptr 0, wptr=1, go to S1_RECV.
  - rx_vld with CR: go to S2_CR.
  - rx_vld with LF: ignored.
- S1_RECV:
  - rx_vld with a non-CR byte: store, wptr+1.
  - rx_vld with CR: go to S2_CR.
  - Any rx_vld clears the idle counter.
  - Idle counter == TIMEOUT_CLK: go to S3_DONE with line_timeout=1.
- S2_CR:
  - rx_vld with LF: go to S3_DONE, terminator consumed and not stored.
  - rx_vld with any other byte: store the pending CR as data, then process the new byte exactly as S1_RECV would (CR → stay in S2_CR; else store it and go to S1_RECV). A full buffer may require two storage cycles; the second store is skipped and counts as overflow.
  - Timeout: store the pending CR if space, go to S3_DONE with line_timeout=1.
- S4_DISCARD: entered when a store is attempted with wptr == BUF_DEPTH; sets line_ovf=1.
  - All bytes are dropped.
  - LF, CR LF or timeout goes to S3_DONE with line_len=BUF_DEPTH.
- S3_DONE: line_vld=1; line_len, line_timeout and line_ovf are stable.
  - Incoming rx_vld bytes are dropped; line_ovf is not changed.
  - line_ack: go to S0_IDLE next cycle; wptr, line_len and flags cleared; line_vld=0.
- line_ack outside S3_DONE is ignored.

Timing and boundary rules:
- line_vld rises on the cycle after the terminating LF strobe, or after the cycle on which the idle counter == TIMEOUT_CLK.
- Idle counter runs only in S1_RECV, S2_CR and S4_DISCARD. It resets on rx_vld or state exit and saturates at TIMEOUT_CLK.
- Empty line (CR LF from S0_IDLE): no line is presented; return to S0_IDLE.
- Simultaneous line_ack and rx_vld in S3_DONE: the byte is dropped and the state goes to S0_IDLE.
- Simultaneous rx_vld and timeout match: the byte wins, the counter clears and no timeout occurs.
- line_len=wptr. Exactly BUF_DEPTH stored bytes followed by CR LF sets no overflow; an additional byte sets overflow.
- rd_data is readable in any state. It returns the buffer as written; stale bytes at or beyond line_len are unspecified.

Test Plan:
1. Send "AB\r\n" (0x41,0x42,0x0D,0x0A) → line_vld=1 one cycle after the LF strobe, line_len=2, rd_addr 0/1 gives 0x41/0x42 one cycle later, flags 0; line_ack → line_vld=0 next cycle.
2. Send "XYZ" then stay idle → line_vld rises TIMEOUT_CLK+1 cycles after the last strobe, line_len=3, line_timeout=1. Also, a gap of TIMEOUT_CLK-1 cycles between bytes must not time out.
3. Send "A\rB\r\n" → line_len=3, buffer holds 0x41,0x0D,0x42, line_timeout=0.
4. Send 64 bytes 0x00..0x3F then CR LF → line_len=64, line_ovf=0. Repeat with 66 bytes then CR LF → line_len=64, line_ovf=1, buffer[63]=0x3F.
5. Send "\r\n" then "Q\r\n" → no line_vld for the empty line; then line_len=1, rd_data=0x51.
6. While in S3_DONE, send "ZZ", then send line_ack in the same cycle as a third rx_vld → all three bytes dropped, next line starts at wptr 0. Assert sys_rst_n low mid-line (after "AB") → all outputs 0 and the next "C\r\n" gives line_len=1.
